// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with RUN/HALT control and an optional LIFO return stack.
// Optional stack enabled by macro PC_STACK_UNIT_STACK_EN.  Rev 1.0
`default_nettype none

module pc_stack_unit #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             call,
   input  logic             ret,
   input  logic             HLT,
   input  logic             OE,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] Bus_out,
   output logic             on,
   output logic             full,
   output logic             empty,
   output logic             err
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t state;

   assign Bus_out = OE ? count : '0;

`ifdef PC_STACK_UNIT_STACK_EN
   // The pointer needs one extra value so that "DEPTH entries" is representable.
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SPW-1:0] SP_LAST = SPW'(DEPTH - 1);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

   logic [WIDTH-1:0] stack_mem [DEPTH];
   logic [SPW-1:0]   sp;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    top_idx;

   assign push_idx = AW'(sp);
   assign top_idx  = AW'(sp - SP_ONE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_RUN;
         on    <= 1'b1;
         count <= '0;
         sp    <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else if (state == S_RUN) begin
         if (HLT) begin
            state <= S_HALT;
            on    <= 1'b0;
         end else if (ret) begin
            if (empty) begin
               err <= 1'b1;
            end else begin
               count <= stack_mem[top_idx];
               sp    <= sp - SP_ONE;
               full  <= 1'b0;
               empty <= (sp == SP_ONE);
            end
         end else if (call) begin
            if (full) begin
               err <= 1'b1;
            end else begin
               stack_mem[push_idx] <= count + WIDTH'(1);
               count <= in;
               sp    <= sp + SP_ONE;
               empty <= 1'b0;
               full  <= (sp == SP_LAST);
            end
         end else if (load) begin
            count <= in;
         end else if (en) begin
            count <= count + WIDTH'(1);
         end
      end
   end
`else
   logic unused_stack_ctrl;
   assign unused_stack_ctrl = call ^ ret;

   assign full  = 1'b0;
   assign empty = 1'b1;
   assign err   = 1'b0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_RUN;
         on    <= 1'b1;
         count <= '0;
      end else if (state == S_RUN) begin
         if (HLT) begin
            state <= S_HALT;
            on    <= 1'b0;
         end else if (load) begin
            count <= in;
         end else if (en) begin
            count <= count + WIDTH'(1);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4: program-counter and address width in bits, legal range 2..16.
REQ-002 SHALL have parameter DEPTH, default 4: return-stack entries, legal range 1..16.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: increment count by 1.
REQ-006 SHALL have port load, input, 1 bit: load count from in.
REQ-007 SHALL have port in, input, WIDTH bits: load or call target address.
REQ-008 SHALL have port call, input, 1 bit: push return address and jump to in.
REQ-009 SHALL have port ret, input, 1 bit: pop the stack into count.
REQ-010 SHALL have port HLT, input, 1 bit: request halt.
REQ-011 SHALL have port OE, input, 1 bit: drive count onto Bus_out.
REQ-012 SHALL have port count, output, WIDTH bits: current program counter.
REQ-013 SHALL have port Bus_out, output, WIDTH bits: count when OE=1, else all zeros.
REQ-014 SHALL have port on, output, 1 bit: 1 in RUN, 0 in HALT.
REQ-015 SHALL have port full, output, 1 bit: stack holds DEPTH entries.
REQ-016 SHALL have port empty, output, 1 bit: stack holds 0 entries.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for stack overflow or underflow.

Function
REQ-018 SHALL implement two states: RUN and HALT.
REQ-019 RUN to HALT SHALL occur on the clock edge at which HLT=1; HALT SHALL be left only by RESET.
REQ-020 In HALT, count, stack and err SHALL hold; all other control inputs are ignored; Bus_out SHALL still follow OE.
REQ-021 In RUN, one action per edge SHALL be taken, in priority order ret > call > load > en; if none is asserted, count holds.
REQ-022 en SHALL set count to count+1 modulo 2^WIDTH; all-ones SHALL wrap to 0 with no flag.
REQ-023 load SHALL set count to in.
REQ-024 call with stack not full SHALL push count+1 (mod 2^WIDTH) and set count to in.
REQ-025 ret with stack not empty SHALL set count to the top entry and pop it.
REQ-026 The stack SHALL be LIFO.
REQ-027 call with full=1 SHALL leave count and the stack unchanged and set err.
REQ-028 ret with empty=1 SHALL leave count and the stack unchanged and set err.
REQ-029 HLT asserted together with any RUN action SHALL suppress that action; count holds.
REQ-030 full, empty, count and on SHALL be registered, with one-cycle update latency.
REQ-031 Bus_out SHALL be combinational from OE and count, with zero latency.

Reset
REQ-032 On a rising edge with RESET=1, reset SHALL override all other inputs and produce: count=0, stack pointer=0, empty=1, full=0, err=0, state RUN (on=1).
REQ-033 Reset SHALL apply mid-operation, including from HALT; stack contents need not be cleared.

Configuration
REQ-034 Macro PC_STACK_UNIT_STACK_EN defined: call, ret, the stack, full, empty and err SHALL behave as in REQ-024 to REQ-028.
REQ-035 Macro PC_STACK_UNIT_STACK_EN undefined: no stack storage SHALL be built; call and ret ignored; full=0, empty=1, err=0 constant.

Verification (WIDTH=4, DEPTH=2, PC_STACK_UNIT_STACK_EN defined)
REQ-036 RESET one cycle, then en=1 for 17 cycles -> count 0..15, then 0, then 1; on=1 throughout.
REQ-037 count=3, call in=9 -> count=9; ret -> count=4, empty=1, err=0.
REQ-038 Two calls (in=5, then in=7) from count=1 -> full=1; third call in=2 -> count stays 7, err=1; two rets -> count 6, then 2.
REQ-039 ret with empty=1 -> count unchanged, err=1, remains 1 until RESET.
REQ-040 count=6, HLT=1 with en=1 -> count stays 6, on=0; en, load, call ignored for 5 cycles; OE=1 -> Bus_out=6; RESET -> count=0, on=1.
REQ-041 load=1, in=0xA, en=1, OE=0 -> count=0xA, Bus_out=0; same edge with ret=1 and a non-empty stack -> popped value wins.
